// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg : opcodes, instruction field layout and sequencer state encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_DIV = 3'b110;
    localparam logic [2:0] OP_CMP = 3'b111;

    localparam int INSTR_W   = 8;
    localparam int OPC_LSB   = 5;
    localparam int OPC_W     = 3;
    localparam int RD_LSB    = 3;
    localparam int RS_LSB    = 1;
    localparam int REG_SEL_W = 2;
    localparam int LAST_BIT  = 0;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_FETCH  = ST_FETCH,
        S_DECODE = ST_DECODE,
        S_EXEC   = ST_EXEC,
        S_WB     = ST_WB,
        S_HALT   = ST_HALT
    } state_t;

endpackage

`default_nettype wire

// File: rtl/instr_decode_reg.sv
// ============================================================================
// instr_decode_reg : instruction register with opcode/rd/rs/last field split
// Rev 1.0
// ============================================================================
`default_nettype none

module instr_decode_reg
    import cpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [INSTR_W-1:0]   instr_in,
    output logic [OPC_W-1:0]     opcode,
    output logic [REG_SEL_W-1:0] rd_sel,
    output logic [REG_SEL_W-1:0] rs_sel,
    output logic                 last
);

    logic [INSTR_W-1:0] ir;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ir <= '0;
        end else if (load) begin
            ir <= instr_in;
        end
    end

    assign opcode = ir[OPC_LSB +: OPC_W];
    assign rd_sel = ir[RD_LSB +: REG_SEL_W];
    assign rs_sel = ir[RS_LSB +: REG_SEL_W];
    assign last   = ir[LAST_BIT];

endmodule

`default_nettype wire

// File: rtl/instr_sequencer.sv
// ============================================================================
// instr_sequencer : fetch/decode/issue/write-back sequencer for the 8-bit CPU
// Rev 1.0
// ============================================================================
`default_nettype none

module instr_sequencer
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic [ADDR_W-1:0]    pmem_addr,
    input  logic [INSTR_W-1:0]   pmem_rdata,
    output logic [OPC_W-1:0]     opcode,
    output logic [REG_SEL_W-1:0] rd_sel,
    output logic [REG_SEL_W-1:0] rs_sel,
    output logic                 alu_valid,
    input  logic                 alu_done,
    output logic                 reg_we,
    output logic                 busy,
    output logic                 halted,
    output logic                 err,
    output logic [ADDR_W-1:0]    pc
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] pc_nx;
    logic              err_nx;
    logic [CNT_W-1:0]  wait_cnt, wait_nx;
    logic              ir_load;
    logic              ir_last;

    instr_decode_reg u_decode (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ir_load),
        .instr_in (pmem_rdata),
        .opcode   (opcode),
        .rd_sel   (rd_sel),
        .rs_sel   (rs_sel),
        .last     (ir_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            pc       <= '0;
            err      <= 1'b0;
            wait_cnt <= '0;
        end else begin
            state    <= state_nx;
            pc       <= pc_nx;
            err      <= err_nx;
            wait_cnt <= wait_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        pc_nx     = pc;
        err_nx    = err;
        wait_nx   = wait_cnt;
        alu_valid = 1'b0;
        reg_we    = 1'b0;
        ir_load   = 1'b0;
        case (state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_nx = S_FETCH;
                    pc_nx    = '0;
                    err_nx   = 1'b0;
                end
            end
            S_FETCH: begin
                state_nx = S_DECODE;
            end
            S_DECODE: begin
                ir_load  = 1'b1;
                wait_nx  = '0;
                state_nx = S_EXEC;
            end
            S_EXEC: begin
                // Counter is zero only in the first EXEC cycle, so it doubles as the issue marker
                alu_valid = (wait_cnt == '0);
                if (alu_done) begin
                    state_nx = S_WB;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nx = S_HALT;
                    err_nx   = 1'b1;
                end else begin
                    wait_nx = wait_cnt + 1'b1;
                end
            end
            S_WB: begin
                reg_we = 1'b1;
                if (ir_last) begin
                    state_nx = S_HALT;
                end else if (pc == {ADDR_W{1'b1}}) begin
                    state_nx = S_HALT;
                    err_nx   = 1'b1;
                end else begin
                    pc_nx    = pc + 1'b1;
                    state_nx = S_FETCH;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    assign pmem_addr = pc;
    assign busy      = (state != S_IDLE) && (state != S_HALT);
    assign halted    = (state == S_HALT);

endmodule

`default_nettype wire

// File: tb/tb_instr_sequencer.sv
// ============================================================================
// tb_instr_sequencer : randomized self-checking bench with a program-level model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_instr_sequencer;

    localparam int ADDR_W  = 4;
    localparam int TIMEOUT = 16;
    localparam int DEPTH   = 2 ** ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] pmem_addr;
    logic [7:0]        pmem_rdata;
    logic [2:0]        opcode;
    logic [1:0]        rd_sel, rs_sel;
    logic              alu_valid, alu_done, reg_we, busy, halted, err;
    logic [ADDR_W-1:0] pc;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [DEPTH];
    int         lat_tab [DEPTH];
    logic [6:0] exp_q [$];
    logic [6:0] last_iss = '0;
    int         n_valid = 0;
    int         n_we = 0;
    bit         mon_en = 1'b0;
    bit         noise_en = 1'b0;
    logic       noise_bit = 1'b0;
    logic       pend = 1'b0;
    int         since = 0;
    int         cur_lat = 0;

    instr_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .pmem_addr(pmem_addr), .pmem_rdata(pmem_rdata),
        .opcode(opcode), .rd_sel(rd_sel), .rs_sel(rs_sel),
        .alu_valid(alu_valid), .alu_done(alu_done), .reg_we(reg_we),
        .busy(busy), .halted(halted), .err(err), .pc(pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) pmem_rdata <= mem[pmem_addr];

    // ALU responder: done arrives lat_tab[pc] cycles after the issue pulse
    always_comb begin
        alu_done = noise_bit;
        if (alu_valid === 1'b1)
            alu_done = (lat_tab[pc] == 0);
        else if (pend)
            alu_done = (since == cur_lat);
    end

    always @(posedge clk) begin
        if (!rst_n || busy !== 1'b1) begin
            pend <= 1'b0;
        end else if (alu_valid && !alu_done) begin
            pend    <= 1'b1;
            since   <= 1;
            cur_lat <= lat_tab[pc];
        end else if (pend) begin
            if (alu_done) pend <= 1'b0;
            else since <= since + 1;
        end
    end

    always @(negedge clk) noise_bit <= noise_en ? 1'($urandom_range(0, 1)) : 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (alu_valid === 1'b1 && reg_we === 1'b1) begin
                errors++;
                $display("FAIL overlap: alu_valid and reg_we both high at pc=%0d", pc);
            end
            if (alu_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_issue: unexpected alu_valid at pc=%0d", pc);
                end else begin
                    if ({opcode, rd_sel, rs_sel} !== exp_q[0]) begin
                        errors++;
                        $display("FAIL issue_fields: got %b expected %b", {opcode, rd_sel, rs_sel}, exp_q[0]);
                    end
                    last_iss = exp_q.pop_front();
                end
                n_valid++;
            end
            if (reg_we === 1'b1) begin
                checks++;
                if ({opcode, rd_sel, rs_sel} !== last_iss) begin
                    errors++;
                    $display("FAIL wb_fields: got %b expected %b", {opcode, rd_sel, rs_sel}, last_iss);
                end
                n_we++;
            end
        end
    end

    // Program-level model: walks the program and totals cycles/results per instruction
    task automatic model(output int cyc, output int nwe, output int fpc, output bit ferr);
        int p;
        logic [7:0] ins;
        cyc = 0; nwe = 0; ferr = 1'b0; p = 0;
        for (int k = 0; k < DEPTH + 1; k++) begin
            ins = mem[p];
            exp_q.push_back(ins[7:1]);
            if (lat_tab[p] >= TIMEOUT) begin
                cyc += 2 + TIMEOUT;
                ferr = 1'b1;
                break;
            end
            cyc += 4 + lat_tab[p];
            nwe++;
            if (ins[0]) break;
            if (p == DEPTH - 1) begin
                ferr = 1'b1;
                break;
            end
            p++;
        end
        fpc = p;
    endtask

    task automatic run_program(input string name, input int ign_cyc);
        int e_cyc, e_we, e_pc, e_iss, cnt;
        bit e_err;
        exp_q.delete();
        model(e_cyc, e_we, e_pc, e_err);
        e_iss = exp_q.size();
        n_valid = 0; n_we = 0; mon_en = 1'b1;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        checks++;
        if (err !== 1'b0 || pc !== '0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s start_state: err=%b pc=%0d busy=%b expected 0/0/1", name, err, pc, busy);
        end
        cnt = 0;
        while (halted !== 1'b1 && cnt < 500) begin
            if (cnt == ign_cyc) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            cnt++;
        end
        mon_en = 1'b0;
        checks++;
        if (cnt != e_cyc) begin errors++; $display("FAIL %s cycles: got %0d expected %0d", name, cnt, e_cyc); end
        checks++;
        if (n_valid != e_iss) begin errors++; $display("FAIL %s issues: got %0d expected %0d", name, n_valid, e_iss); end
        checks++;
        if (n_we != e_we) begin errors++; $display("FAIL %s writebacks: got %0d expected %0d", name, n_we, e_we); end
        checks++;
        if (pc !== ADDR_W'(e_pc)) begin errors++; $display("FAIL %s final_pc: got %0d expected %0d", name, pc, e_pc); end
        checks++;
        if (err !== e_err) begin errors++; $display("FAIL %s err: got %b expected %b", name, err, e_err); end
        checks++;
        if (busy !== 1'b0 || halted !== 1'b1) begin
            errors++;
            $display("FAIL %s halt_flags: busy=%b halted=%b expected 0/1", name, busy, halted);
        end
    endtask

    task automatic fill_random(input int max_lat);
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = 8'($urandom);
            lat_tab[i] = $urandom_range(0, max_lat);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({alu_valid, reg_we, busy, halted, err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000", {alu_valid, reg_we, busy, halted, err});
        end
        checks++;
        if (pc !== '0 || pmem_addr !== '0) begin
            errors++; $display("FAIL reset_addr: pc=%0d pmem_addr=%0d expected 0", pc, pmem_addr);
        end
        checks++;
        if ({opcode, rd_sel, rs_sel} !== 7'b0) begin
            errors++; $display("FAIL reset_fields: got %b expected 0", {opcode, rd_sel, rs_sel});
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_single();
        fill_random(3);
        mem[0] = 8'b010_01_10_1;
        lat_tab[0] = 0;
        run_program("single", -1);
        checks++;
        if (opcode !== 3'b010 || rd_sel !== 2'd1 || rs_sel !== 2'd2) begin
            errors++;
            $display("FAIL single_fields: got %b/%0d/%0d expected 010/1/2", opcode, rd_sel, rs_sel);
        end
    endtask

    task automatic test_multicycle();
        fill_random(3);
        mem[0] = 8'b110_00_01_0;
        lat_tab[0] = 5;
        mem[1] = mem[1] | 8'h01;
        run_program("multicycle", -1);
    endtask

    task automatic test_timeout();
        fill_random(3);
        lat_tab[0] = TIMEOUT;
        run_program("timeout", -1);
        fill_random(3);
        mem[0] = mem[0] | 8'h01;
        lat_tab[0] = TIMEOUT - 1;
        run_program("timeout_edge", -1);
    endtask

    task automatic test_overrun();
        fill_random(3);
        for (int i = 0; i < DEPTH; i++) mem[i] = mem[i] & 8'hFE;
        run_program("overrun", -1);
    endtask

    task automatic test_start_ignored();
        fill_random(2);
        mem[0] = mem[0] & 8'hFE;
        lat_tab[0] = 6;
        mem[1] = mem[1] | 8'h01;
        run_program("start_busy", 4);
    endtask

    task automatic test_midreset();
        int cnt;
        fill_random(2);
        lat_tab[0] = 8;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cnt = 0;
        while (alu_valid !== 1'b1 && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        checks++;
        if (alu_valid !== 1'b1) begin
            errors++; $display("FAIL midreset_issue: alu_valid=%b expected 1", alu_valid);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({alu_valid, reg_we, busy, halted, err} !== 5'b0 || pc !== '0 || {opcode, rd_sel, rs_sel} !== 7'b0) begin
            errors++;
            $display("FAIL midreset_outputs: flags=%b pc=%0d fields=%b expected 0", {alu_valid, reg_we, busy, halted, err}, pc, {opcode, rd_sel, rs_sel});
        end
        @(negedge clk); rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (alu_valid !== 1'b0 || reg_we !== 1'b0 || busy !== 1'b0) cnt++;
        end
        checks++;
        if (cnt != 0) begin
            errors++; $display("FAIL midreset_quiet: got %0d active cycles expected 0", cnt);
        end
    endtask

    task automatic test_random();
        noise_en = 1'b1;
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] = 8'($urandom);
                mem[i][0] = ($urandom_range(0, 3) == 0);
                lat_tab[i] = ($urandom_range(0, 9) == 0) ? TIMEOUT : $urandom_range(0, TIMEOUT - 1);
            end
            run_program("random", -1);
        end
        noise_en = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = '0;
            lat_tab[i] = 0;
        end
        test_reset();
        test_single();
        test_multicycle();
        test_timeout();
        test_overrun();
        test_start_ignored();
        test_midreset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Producer side of the opcode interface feeding control_unit: fetches 8-bit instructions from program memory and splits them into fields.
- Drives `opcode` and register selects, issues one ALU operation at a time with a valid/done handshake, then pulses register write-back.
- Sits between program memory and the control_unit/ALU/register-file datapath of the 8-bit CPU.

Parameters:
ADDR_W, 4, program-memory address width; PROG_DEPTH = 2**ADDR_W.
TIMEOUT, 16, max cycles to wait for alu_done before error-halt (>=1).

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  synchronous active-low reset.
start  in  1  begin execution from address 0; sampled only in IDLE or HALT.
pmem_addr  out  ADDR_W  program-memory read address.
pmem_rdata  in  8  instruction; synchronous memory, valid the cycle after pmem_addr is driven.
opcode  out  3  to control_unit; instr[7:5].
rd_sel  out  2  destination register; instr[4:3].
rs_sel  out  2  source register; instr[2:1].
alu_valid  out  1  one-cycle issue pulse.
alu_done  in  1  ALU result ready; may be asserted in the same cycle as alu_valid.
reg_we  out  1  one-cycle register-file write enable.
busy  out  1  high in every state except IDLE and HALT.
halted  out  1  high in HALT.
err  out  1  sticky; set on timeout or program overrun, cleared by start or reset.
pc  out  ADDR_W  current instruction address.

Behaviour:
- Clock and reset: single clock `clk`; reset `rst_n` is synchronous and active-low.
- Reset values: state=IDLE, pc=0, pmem_addr=0, opcode=0, rd_sel=0, rs_sel=0, alu_valid=0, reg_we=0, busy=0, halted=0, err=0.
- Instruction format: [7:5] opcode, [4:3] rd, [2:1] rs, [0] last (halt after write-back).
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT.
- IDLE: on start=1 -> FETCH, pc=0, err=0.
- FETCH: pmem_addr=pc -> DECODE.
- DECODE: latch pmem_rdata into the instruction register; opcode/rd_sel/rs_sel update from the next cycle and hold stable until the next DECODE -> EXEC.
- EXEC:
  - alu_valid=1 only in the first EXEC cycle.
  - Remain in EXEC until alu_done=1, then -> WB.
  - Wait counter starts at 0 on EXEC entry and increments each cycle without done.
  - If the counter reaches TIMEOUT with no done -> HALT, err=1, no reg_we.
- WB: reg_we=1 for exactly one cycle.
  - If last=1 -> HALT.
  - Else if pc==PROG_DEPTH-1 -> HALT with err=1 (overrun; pc does not wrap).
  - Else pc=pc+1 -> FETCH.
- HALT: halted=1, outputs hold; start=1 -> FETCH with pc=0, err=0.
- Latency: minimum 4 cycles per instruction (FETCH, DECODE, EXEC with same-cycle done, WB).
- start while busy is ignored. alu_done outside EXEC is ignored.
- Reset mid-operation: the next edge with rst_n=0 forces the reset values regardless of state; an in-flight alu_valid/reg_we pulse is suppressed.
- alu_valid and reg_we are never high in the same cycle.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants OP_ADD..OP_CMP (3'b000..3'b111);
  - instruction field positions/widths;
  - state encoding constants for the six states.
- The same opcode constants are reused by control_unit.
- One natural sub-module: instr_decode_reg (instruction register plus field split). Everything else stays in the top FSM.

Test Plan:
1. Reset/idle: rst_n=0 for 2 cycles, start=0 -> all outputs 0, state IDLE, pmem_addr=0.
2. Single-instruction program: mem[0]=8'b010_01_10_1 (AND, rd=1, rs=2, last), alu_done tied 1, pulse start -> alu_valid 3 cycles after start, opcode=3'b010, rd_sel=1, rs_sel=2, reg_we the next cycle, then halted=1, err=0.
3. Multi-cycle ALU: DIV (mem[0]=8'b110_00_01_0) with alu_done asserted 5 cycles after alu_valid, mem[1] last -> one alu_valid pulse only, opcode held at 110, reg_we once, pc advances to 1.
4. Timeout: TIMEOUT=16, alu_done held 0 -> HALT after 16 EXEC cycles, err=1, no reg_we; a later start clears err and restarts at pc=0.
5. Overrun: ADDR_W=2, four instructions with no last bit -> four reg_we pulses, then HALT with err=1 and pc=3.
6. Mid-run reset plus ignored start: assert rst_n=0 during EXEC -> outputs reset next edge, no alu_valid/reg_we pulse; start pulsed while busy -> no effect on pc or state.
